// File: rtl/bcd_7seg_scanner.sv
// Time-multiplexed N-digit BCD 7-segment scanner with frame-synchronous updates,
// ghost blanking at slot start, leading-zero suppression and per-digit decimal point.
module bcd_7seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int LZ_BLANK       = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_bcd_data,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_frame_done
);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;

  logic                  w_wrap;
  logic                  w_show;
  logic [3:0]            w_digit;
  logic                  w_dp_sel;
  logic                  w_lz_blank;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [6:0]            w_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000001;
    endcase
  endfunction

  assign w_wrap = (r_cnt == CNT_LAST) && (r_idx == IDX_LAST) && i_en;
  assign w_show = i_en && (32'(r_cnt) >= BLANK_CYCLES);

  // Walk from the most significant digit down; the zero run ends at the first non-zero code.
  always_comb begin
    w_digit    = 4'd0;
    w_dp_sel   = 1'b0;
    w_lz_blank = 1'b0;
    w_zero_run = 1'b1;
    w_an_hot   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_act_data[4*k +: 4] == 4'd0);
      if (IDX_W'(k) == r_idx) begin
        w_digit     = r_act_data[4*k +: 4];
        w_dp_sel    = r_act_dp[k];
        w_lz_blank  = (LZ_BLANK != 0) && (k != 0) && w_zero_run;
        w_an_hot[k] = 1'b1;
      end
    end
  end

  assign w_seg = w_lz_blank ? 7'b0000000 : seg_decode(w_digit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A load in the wrap cycle bypasses the shadow so it shows in the very next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pending     <= 1'b0;
      r_act_data    <= '0;
      r_act_dp      <= '0;
    end else begin
      if (i_load) begin
        r_shadow_data <= i_bcd_data;
        r_shadow_dp   <= i_dp_in;
      end
      if (w_wrap) begin
        r_pending <= 1'b0;
        if (i_load) begin
          r_act_data <= i_bcd_data;
          r_act_dp   <= i_dp_in;
        end else if (r_pending) begin
          r_act_data <= r_shadow_data;
          r_act_dp   <= r_shadow_dp;
        end
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg        <= SEG_OFF;
      o_dp         <= DP_OFF;
      o_an         <= AN_OFF;
      o_digit_idx  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_seg        <= (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
      o_dp         <= (SEG_ACTIVE_LOW != 0) ? ~w_dp_sel : w_dp_sel;
      o_an         <= w_show ? ((AN_ACTIVE_LOW != 0) ? ~w_an_hot : w_an_hot) : AN_OFF;
      o_digit_idx  <= r_idx;
      o_frame_done <= w_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Directed bench for bcd_7seg_scanner with a 4-digit, 4-cycle-slot, 1-blank-cycle setup.
module tb_bcd_7seg_scanner;

  localparam int N = 4;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] SDASH  = 7'b0000001;
  localparam logic [6:0] SBLANK = 7'b0000000;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [4*N-1:0] bcd_data;
  logic [N-1:0]  dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic [1:0]    digit_idx;
  logic          frame_done;

  int n_checks = 0;
  int n_errors = 0;

  bcd_7seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load),
    .i_bcd_data(bcd_data), .i_dp_in(dp_in),
    .o_seg(seg), .o_dp(dp), .o_an(an), .o_digit_idx(digit_idx),
    .o_frame_done(frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    load     = 1'b1;
    bcd_data = d;
    dp_in    = p;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_frame_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_slot(input string tag, input int k, input logic [6:0] exp_seg,
                            input logic exp_dp);
    logic ok;
    logic [3:0] exp_an;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (32'(digit_idx) == k && an != 4'b1111) begin
        ok = 1'b1;
        break;
      end
    end
    exp_an = ~(4'b0001 << k);
    check_eq({tag, "_slot_seen"}, 32'(ok), 32'd1);
    check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    check_eq({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    check_eq({tag, "_an"}, 32'(an), 32'(exp_an));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_seg"}, 32'(seg), 32'h0);
    check_eq({tag, "_dp"}, 32'(dp), 32'h0);
    check_eq({tag, "_idx"}, 32'(digit_idx), 32'h0);
    check_eq({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd_data = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // release: first slot cycle blanked, then digit 0 shows 0
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    check_eq("blank_an", 32'(an), 32'hF);
    check_eq("blank_idx", 32'(digit_idx), 32'h0);
    @(negedge clk);
    check_eq("d0_an", 32'(an), 32'hE);
    check_eq("d0_seg", 32'(seg), 32'(S0));
    check_slot("lz1", 1, SBLANK, 1'b0);
    check_slot("lz2", 2, SBLANK, 1'b0);
    check_slot("lz3", 3, SBLANK, 1'b0);

    // frame period
    wait_frame("per");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) break;
    end
    check_eq("frame_period", 32'(n), 32'd16);

    // mid-frame load is held back until the wrap
    check_slot("pre1", 1, SBLANK, 1'b0);
    pulse_load(16'h1234, 4'b0100);
    check_slot("old2", 2, SBLANK, 1'b0);
    check_slot("old3", 3, SBLANK, 1'b0);
    wait_frame("l1234");
    check_slot("n0", 0, S4, 1'b0);
    check_slot("n1", 1, S3, 1'b0);
    check_slot("n2", 2, S2, 1'b1);
    check_slot("n3", 3, S1, 1'b0);

    // leading-zero suppression, digit 0 never blanked
    pulse_load(16'h0050, 4'b0000);
    wait_frame("l0050");
    check_slot("z0", 0, S0, 1'b0);
    check_slot("z1", 1, S5, 1'b0);
    check_slot("z2", 2, SBLANK, 1'b0);
    check_slot("z3", 3, SBLANK, 1'b0);

    pulse_load(16'h00A0, 4'b0000);
    wait_frame("l00a0");
    check_slot("a0", 0, S0, 1'b0);
    check_slot("a1", 1, SDASH, 1'b0);
    check_slot("a2", 2, SBLANK, 1'b0);
    check_slot("a3", 3, SBLANK, 1'b0);

    // two loads in one frame: only the last is shown
    wait_frame("dbl");
    check_slot("dbl_pre1", 1, SDASH, 1'b0);
    pulse_load(16'h1111, 4'b0000);
    check_slot("dbl_pre2", 2, SBLANK, 1'b0);
    pulse_load(16'h2222, 4'b0000);
    wait_frame("dbl_wrap");
    check_slot("dbl0", 0, S2, 1'b0);
    check_slot("dbl1", 1, S2, 1'b0);
    check_slot("dbl2", 2, S2, 1'b0);
    check_slot("dbl3", 3, S2, 1'b0);

    // load exactly in the wrap cycle (15 cycles after a visible frame_done)
    wait_frame("wrapld");
    repeat (15) @(negedge clk);
    pulse_load(16'h5678, 4'b0001);
    check_eq("wrapld_fd", 32'(frame_done), 32'd1);
    check_slot("w0", 0, S8, 1'b1);
    check_slot("w1", 1, S7, 1'b0);
    check_slot("w2", 2, S6, 1'b0);
    check_slot("w3", 3, S5, 1'b0);

    // en low mid-slot freezes the scan and blanks the anodes
    wait_frame("en");
    check_slot("en_pre1", 1, S7, 1'b0);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an != 4'b1111 || digit_idx != 2'd1) bad++;
    end
    check_eq("en_freeze_bad", 32'(bad), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check_eq("en_resume_an", 32'(an), 32'hD);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (digit_idx != 2'd1) break;
      n++;
    end
    check_eq("en_resume_len", 32'(n), 32'd2);

    // reset with a pending load discards it
    wait_frame("rstm");
    check_slot("rstm1", 1, S7, 1'b0);
    pulse_load(16'h9999, 4'b1111);
    check_slot("rstm2", 2, S6, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("rst_after");
    check_slot("ra0", 0, S0, 1'b0);
    check_slot("ra1", 1, SBLANK, 1'b0);
    check_slot("ra3", 3, SBLANK, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scanner.md
# bcd_7seg_scanner

Time-multiplexed driver for an N-digit common-anode/common-cathode 7-segment display. Holds an N-digit packed BCD value, scans one digit at a time at a parametrised refresh rate, and drives shared segment lines plus one-hot digit enables. Adds tear-free frame-synchronous updates, inter-digit ghost blanking, leading-zero suppression and a per-digit decimal point. Sits between the counter/datapath logic producing BCD and the board's display pins.

## Interface

- NUM_DIGITS, 4: digits scanned; ≥1.
- REFRESH_DIV, 1000: clk cycles per digit slot; ≥2.
- BLANK_CYCLES, 8: cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 1: 1 means an bit = 0 enables a digit.
- LZ_BLANK, 1: 1 enables leading-zero suppression.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; low freezes scan and blanks display.
- load  in  1  single-cycle strobe capturing bcd_data/dp_in.
- bcd_data  in  4*NUM_DIGITS  packed BCD; digit k = bits [4k+3:4k], digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- seg  out  7  segments a..g at bits 6..0.
- dp  out  1  decimal point of the digit being driven.
- an  out  NUM_DIGITS  digit enables, one-hot or all-off.
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  index of the current slot.
- frame_done  out  1  one-cycle pulse at frame wrap.

## Operation

- Logical segment encoding (before SEG_ACTIVE_LOW): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, 10–15 = 0000001 (dash).
- Registers: shadow (data+dp), pending flag, active (data+dp), prescaler cnt [0..REFRESH_DIV-1], slot idx [0..NUM_DIGITS-1].
- load=1: shadow <= {bcd_data, dp_in}, pending <= 1. A second load before the frame wrap overwrites the shadow; only the last is shown.
- Frame wrap = cnt == REFRESH_DIV-1 and idx == NUM_DIGITS-1 and en. On wrap: if pending, active <= shadow, pending <= 0. A load in the wrap cycle goes straight to active and leaves pending at 0.
- Scan with en=1: cnt increments; on terminal count cnt <= 0 and idx increments, wrapping N-1 -> 0. Order 0,1,…,N-1.
- en=0: cnt and idx hold, an all off, load still captured.
- Leading-zero suppression (LZ_BLANK=1): digits from N-1 downward whose value is 0 are blanked (seg off, dp still per dp_in) until the first non-zero digit. Digit 0 is never blanked. Invalid codes count as non-zero.
- Blanking: an is all off while cnt < BLANK_CYCLES.

## Timing

- Reset (async assert, sync deassert by the system): cnt=0, idx=0, shadow=active=0, pending=0. Outputs: an all off (all 1 if AN_ACTIVE_LOW), seg/dp off at pin polarity, digit_idx=0, frame_done=0.
- All outputs are registered: seg/dp/an/digit_idx in cycle t+1 reflect cnt/idx/active in cycle t. frame_done is high in the cycle after the wrap cycle, for exactly 1 cycle.
- Update latency: load to display is at most one frame (NUM_DIGITS*REFRESH_DIV cycles) + 1. The value is never mixed within a frame.
- Reset mid-frame returns immediately to the reset state and discards the pending shadow.
- en rising: scan resumes from the held cnt/idx. an follows the blanking rule one cycle later.

## Test plan

Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1, LZ_BLANK=1.

- Reset then release with en=1, no load -> an=1111 during blank cycles; digit 0 shows seg=1111110 with an=1110; digits 1–3 are blanked as leading zeros (seg=0000000); frame_done pulses every 16 cycles.
- Load bcd_data=0x1234, dp_in=0100 mid-frame -> the old value persists to the end of the frame. The next frame shows digit0=0110011 (4), digit1=1111001, digit2=1101101 with dp=1, digit3=0110000.
- Load 0x0050 -> digits 3 and 2 are blank, digit1=1011011, digit0=1111110 (not blanked); load 0x00A0 -> digit1=0000001 (dash).
- Two loads (0x1111, then 0x2222) within one frame -> only 0x2222 is ever displayed. A load coinciding with the wrap cycle -> its value is shown in the immediately following frame.
- Drop en for 10 cycles mid-slot -> an=1111 throughout and digit_idx is frozen; on resume the slot completes its remaining cycles.
- Assert reset mid-scan after a pending load -> outputs return to reset values asynchronously; after release the display shows 0, not the pending value.
